// File: rtl/video_line_fetch_if.sv
// video_line_fetch_if: strobes, renderer/palette write ports and pixel outputs of the line fetch stage
interface video_line_fetch_if;
  logic        next_frame;
  logic        next_line;
  logic        next_pixel;
  logic        render_start;
  logic [8:0]  render_line;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_done;
  logic        pal_wr_en;
  logic [7:0]  pal_addr;
  logic [11:0] pal_wr_data;
  logic [7:0]  border_color;
  logic [11:0] palette_rgb_data;
  logic        underrun;
  modport master (
    output next_frame, next_line, next_pixel, wr_en, wr_addr, wr_data, wr_done,
           pal_wr_en, pal_addr, pal_wr_data, border_color,
    input  render_start, render_line, palette_rgb_data, underrun
  );
  modport slave (
    input  next_frame, next_line, next_pixel, wr_en, wr_addr, wr_data, wr_done,
           pal_wr_en, pal_addr, pal_wr_data, border_color,
    output render_start, render_line, palette_rgb_data, underrun
  );
endinterface

// File: rtl/video_line_fetch.sv
// video_line_fetch: double-buffered line buffer plus palette, 2-clock pixel pipeline and render handshake
module video_line_fetch #(
  parameter int H_PIXELS = 640,
  parameter int H_REPEAT = 2
) (
  input logic clk,
  input logic rst,
  video_line_fetch_if.slave bus
);
  localparam int SW = $clog2(H_REPEAT + 1);
  logic [7:0]    lb [2048];
  logic [11:0]   pal [256];
  logic          disp_sel, back_ready, blank_line, ready;
  logic [SW-1:0] sub;
  logic [9:0]    pix;
  logic [7:0]    rd, bcol;
  logic          bsel, v1;
  logic [11:0]   rgb;
  logic          render_start, underrun;
  logic [8:0]    render_line;
  // a wr_done arriving with next_line still counts as a ready buffer
  assign ready = back_ready | bus.wr_done;
  assign bus.render_start = render_start;
  assign bus.render_line = render_line;
  assign bus.underrun = underrun;
  assign bus.palette_rgb_data = rgb;
  always_ff @(posedge clk) begin
    if (bus.wr_en && !back_ready && bus.wr_addr < 10'(H_PIXELS)) lb[{~disp_sel, bus.wr_addr}] <= bus.wr_data;
    if (bus.pal_wr_en) pal[bus.pal_addr] <= bus.pal_wr_data;
    rd <= lb[{disp_sel, pix}];
    bsel <= blank_line || pix >= 10'(H_PIXELS);
    bcol <= bus.border_color;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_sel <= 1'b0;
      back_ready <= 1'b0;
      blank_line <= 1'b1;
      sub <= '0;
      pix <= '0;
      v1 <= 1'b0;
      rgb <= '0;
      render_start <= 1'b0;
      render_line <= '0;
      underrun <= 1'b0;
    end else begin
      render_start <= bus.next_frame || (bus.next_line && ready);
      underrun <= !bus.next_frame && bus.next_line && !ready;
      if (bus.next_frame) begin
        back_ready <= 1'b0;
        render_line <= '0;
        blank_line <= 1'b1;
      end else if (bus.next_line) begin
        if (ready) begin
          disp_sel <= ~disp_sel;
          back_ready <= 1'b0;
          blank_line <= 1'b0;
          render_line <= render_line + 9'd1;
        end else blank_line <= 1'b1;
      end else if (bus.wr_done) back_ready <= 1'b1;
      if (bus.next_line) begin
        sub <= '0;
        pix <= '0;
      end else if (bus.next_pixel) begin
        sub <= (sub == SW'(H_REPEAT - 1)) ? '0 : sub + SW'(1);
        if (sub == SW'(H_REPEAT - 1) && pix != 10'(H_PIXELS)) pix <= pix + 10'd1;
      end
      v1 <= bus.next_pixel;
      rgb <= v1 ? pal[bsel ? bcol : rd] : 12'h000;
    end
  end
endmodule

// File: doc/video_line_fetch.md
# video_line_fetch

Upstream pixel-source stage for the composite/RGB video timing block. Holds a double-buffered 8-bit-index line buffer, filled by a line renderer, and a 256-entry 12-bit palette. Driven by the timing block's `next_frame` / `next_line` / `next_pixel` strobes, it produces `palette_rgb_data` through a fixed 2-clock pipeline. It also runs the per-line render handshake, including underrun detection.

## Interface
- `H_PIXELS`, 640: source pixels per line.
- `H_REPEAT`, 2: clocks per source pixel (640 × 2 = 1280 active clocks).
- `clk`  in  1  video clock.
- `rst`  in  1  reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- `next_frame`  in  1  one-clock strobe, precedes the first active line of a field.
- `next_line`  in  1  one-clock strobe, one clock before a line's active window.
- `next_pixel`  in  1  high on every active clock.
- `render_start`  out  1  one-clock pulse: renderer must fill the back buffer.
- `render_line`  out  9  field line index the renderer must produce; valid when `render_start`=1.
- `wr_en`  in  1  line buffer write strobe.
- `wr_addr`  in  10  back-buffer pixel address.
- `wr_data`  in  8  palette index.
- `wr_done`  in  1  one-clock pulse: back buffer complete.
- `pal_wr_en`  in  1  palette write strobe.
- `pal_addr`  in  8  palette address.
- `pal_wr_data`  in  12  RGB444 value {R,G,B}.
- `border_color`  in  8  palette index used outside valid pixels.
- `palette_rgb_data`  out  12  pixel colour.
- `underrun`  out  1  one-clock pulse: line missed, border shown.

## Operation
- Line buffer: two 1024×8 banks. `disp_sel` selects the display bank; the other bank is the back bank.
  - Writes go only to the back bank, and only while `back_ready`=0. Writes with `wr_addr` ≥ `H_PIXELS` are dropped.
- `back_ready`: set by `wr_done`, cleared on swap and on `next_frame`. `wr_done` while `back_ready`=1 is ignored.
- On `next_frame`:
  - `back_ready`←0, `render_line`←0, `blank_line`←1.
  - `render_start` pulses next clock.
  - `disp_sel` is unchanged.
- On `next_line` with `back_ready`=1, or with `wr_done` in the same clock (counts as ready):
  - `disp_sel` toggles, `back_ready`←0, `blank_line`←0.
  - `render_line`←`render_line`+1 (9-bit wrap).
  - `render_start` pulses next clock.
- On `next_line` with no ready buffer:
  - `blank_line`←1; `underrun` pulses next clock.
  - No swap, no `render_start`; the renderer keeps filling the same line.
- `next_frame` and `next_line` in the same clock: `next_frame` wins.
- Pixel counters `sub` (0..`H_REPEAT`-1) and `pix` (10 bit):
  - Both cleared on `next_line`.
  - On each `next_pixel` clock, `sub` advances; when `sub` wraps, `pix` increments.
  - `pix` saturates at `H_PIXELS`.
- Pixel index selection:
  - `pix` < `H_PIXELS` and `blank_line`=0: index = display bank[`pix`].
  - Otherwise: index = `border_color`.
- Palette: single 256×12 RAM. Write port is `pal_*`. A read and a write to the same address in the same clock return the old value (read-first). Contents are not reset.

## Timing
- Pipeline:
  - S0: the `next_pixel` clock presents the address.
  - S1: the index is registered (the border select is registered alongside it).
  - S2: `palette_rgb_data` is registered.
  - Latency is exactly 2 clocks from the `next_pixel` clock to its colour. The timing consumer delays sync/active by 2 to align.
- A clock with `next_pixel`=0 yields `palette_rgb_data`=12'h000 two clocks later.
- Reset values:
  - Outputs: `palette_rgb_data`=0, `render_start`=0, `render_line`=0, `underrun`=0.
  - Internal state: `disp_sel`=0, `back_ready`=0, `blank_line`=1, `sub`=0, `pix`=0, pipeline valid=0.
- Reset mid-line: the pipeline is flushed; output is 0 from the clock after `rst`, until the next `next_pixel`+2.
- `render_start` / `underrun` are registered: they assert 1 clock after the triggering strobe, for 1 clock.
- The swap takes effect on the `next_line` clock. The first `next_pixel` (the clock after) reads the new bank.

## Test plan
- **Reset:** assert `rst` for 3 clocks mid-line → `palette_rgb_data`=0, `render_start`=0, `underrun`=0, `render_line`=0; pipeline output 0 until 2 clocks after the next `next_pixel`.
- **Normal line:**
  - Setup: palette[5]=12'hF80; back bank filled with 5 at address 0 and 7 elsewhere; palette[7]=12'h00F; `wr_done`, then `next_line`.
  - Required: pixel 0 shows 12'hF80 on output clocks 2 and 3 after the first `next_pixel`, then 12'h00F; `render_start` pulses with `render_line`=1.
- **Underrun:** `next_line` with no `wr_done` → `underrun` pulses once; whole line = palette[`border_color`]; no `render_start`. A later `wr_done` then `next_line` → swap, `render_line` advances by 1 only.
- **Simultaneous strobes:**
  - `wr_done` and `next_line` in the same clock → swap, no underrun.
  - `next_frame` and `next_line` in the same clock → `render_line`=0, `render_start` pulses, current line blank.
- **Write guards:**
  - Writes while `back_ready`=1 leave the buffer unchanged.
  - `wr_addr`=700 is dropped.
  - Palette write to an address read in the same clock → old value output, new value on the next read.
